// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and decodes every datapath select, ALU operation and write strobe from the state.
module mips_multicycle_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero_flag,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       MemWrite,
   output logic       IorD,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       Branch,
   output logic       pc_en,
   output logic [1:0] PCSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic [2:0] alu_control,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StAluWb  = 4'd7,
      StBranch = 4'd8,
      StAddiEx = 4'd9,
      StAddiWb = 4'd10,
      StJump   = 4'd11
   } state_t;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;

   state_t     state_q, state_d;
   logic       funct_ok;
   logic [2:0] funct_alu;

   always_ff @(posedge clk) begin
      if (rst) state_q <= StFetch;
      else     state_q <= state_d;
   end

   assign state = state_q;

   // R-type funct decode; unknown functs fall back to add.
   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = 3'b010;
      case (funct)
         6'b100000: funct_alu = 3'b010;
         6'b100010: funct_alu = 3'b110;
         6'b100100: funct_alu = 3'b000;
         6'b100101: funct_alu = 3'b001;
         6'b101010: funct_alu = 3'b111;
         default:   funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = StFetch;
      mem_req     = 1'b0;
      MemWrite    = 1'b0;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      Branch      = 1'b0;
      PCSrc       = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      alu_control = 3'b000;
      illegal_op  = 1'b0;

      case (state_q)
         StFetch: begin
            mem_req     = 1'b1;
            ALUSrcB     = 2'b01;
            alu_control = 3'b010;
            IRWrite     = mem_ready;
            PCWrite     = mem_ready;
            state_d     = mem_ready ? StDecode : StFetch;
         end
         StDecode: begin
            // Precompute the branch target while the opcode is decoded.
            ALUSrcB     = 2'b11;
            alu_control = 3'b010;
            case (opcode)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype: begin
                  if (funct_ok) begin
                     state_d = StExec;
                  end else begin
                     state_d    = StFetch;
                     illegal_op = 1'b1;
                  end
               end
               OpBeq:  state_d = StBranch;
               OpAddi: state_d = StAddiEx;
               OpJ:    state_d = StJump;
               default: begin
                  state_d    = StFetch;
                  illegal_op = 1'b1;
               end
            endcase
         end
         StMemAdr: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b10;
            alu_control = 3'b010;
            state_d     = (opcode == OpLw) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            mem_req = 1'b1;
            IorD    = 1'b1;
            state_d = mem_ready ? StMemWb : StMemRd;
         end
         StMemWb: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            state_d  = StFetch;
         end
         StMemWr: begin
            mem_req  = 1'b1;
            IorD     = 1'b1;
            MemWrite = 1'b1;
            state_d  = mem_ready ? StFetch : StMemWr;
         end
         StExec: begin
            ALUSrcA     = 1'b1;
            alu_control = funct_alu;
            state_d     = StAluWb;
         end
         StAluWb: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            state_d  = StFetch;
         end
         StBranch: begin
            ALUSrcA     = 1'b1;
            alu_control = 3'b110;
            Branch      = 1'b1;
            PCSrc       = 2'b01;
            state_d     = StFetch;
         end
         StAddiEx: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b10;
            alu_control = 3'b010;
            state_d     = StAddiWb;
         end
         StAddiWb: begin
            RegWrite = 1'b1;
            state_d  = StFetch;
         end
         StJump: begin
            PCSrc   = 2'b10;
            PCWrite = 1'b1;
            state_d = StFetch;
         end
         default: state_d = StFetch;
      endcase

      // During reset present the FETCH selects with every strobe suppressed.
      if (rst) begin
         mem_req     = 1'b0;
         MemWrite    = 1'b0;
         IorD        = 1'b0;
         IRWrite     = 1'b0;
         PCWrite     = 1'b0;
         Branch      = 1'b0;
         PCSrc       = 2'b00;
         ALUSrcA     = 1'b0;
         ALUSrcB     = 2'b01;
         RegDst      = 1'b0;
         MemtoReg    = 1'b0;
         RegWrite    = 1'b0;
         alu_control = 3'b010;
         illegal_op  = 1'b0;
      end

      pc_en = PCWrite | (Branch & zero_flag);
   end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed, table-driven bench for mips_multicycle_controller: one vector per clock cycle,
// plus a hand-written reset-during-stalled-store sequence.
module tb_mips_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   logic       zero_flag, mem_ready;
   logic       mem_req, MemWrite, IorD, IRWrite, PCWrite, Branch, pc_en;
   logic [1:0] PCSrc, ALUSrcB;
   logic       ALUSrcA, RegDst, MemtoReg, RegWrite, illegal_op;
   logic [2:0] alu_control;
   logic [3:0] state;

   always #5 clk = ~clk;

   mips_multicycle_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero_flag(zero_flag),
      .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .pc_en(pc_en), .PCSrc(PCSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .alu_control(alu_control), .illegal_op(illegal_op), .state(state)
   );

   // {mem_req, MemWrite, IorD, IRWrite, PCWrite, Branch, pc_en, PCSrc,
   //  ALUSrcA, ALUSrcB, RegDst, MemtoReg, RegWrite, alu_control, illegal_op}
   typedef logic [18:0] out_t;

   localparam out_t O_RST  = {7'b0000000, 2'b00, 1'b0, 2'b01, 3'b000, 3'b010, 1'b0};
   localparam out_t O_FRDY = {7'b1001101, 2'b00, 1'b0, 2'b01, 3'b000, 3'b010, 1'b0};
   localparam out_t O_FSTL = {7'b1000000, 2'b00, 1'b0, 2'b01, 3'b000, 3'b010, 1'b0};
   localparam out_t O_DEC  = {7'b0000000, 2'b00, 1'b0, 2'b11, 3'b000, 3'b010, 1'b0};
   localparam out_t O_ILL  = {7'b0000000, 2'b00, 1'b0, 2'b11, 3'b000, 3'b010, 1'b1};
   localparam out_t O_MADR = {7'b0000000, 2'b00, 1'b1, 2'b10, 3'b000, 3'b010, 1'b0};
   localparam out_t O_MRD  = {7'b1010000, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0};
   localparam out_t O_MWB  = {7'b0000000, 2'b00, 1'b0, 2'b00, 3'b011, 3'b000, 1'b0};
   localparam out_t O_MWR  = {7'b1110000, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0};
   localparam out_t O_EXSB = {7'b0000000, 2'b00, 1'b1, 2'b00, 3'b000, 3'b110, 1'b0};
   localparam out_t O_ALWB = {7'b0000000, 2'b00, 1'b0, 2'b00, 3'b101, 3'b000, 1'b0};
   localparam out_t O_BRZ1 = {7'b0000011, 2'b01, 1'b1, 2'b00, 3'b000, 3'b110, 1'b0};
   localparam out_t O_BRZ0 = {7'b0000010, 2'b01, 1'b1, 2'b00, 3'b000, 3'b110, 1'b0};
   localparam out_t O_AIEX = {7'b0000000, 2'b00, 1'b1, 2'b10, 3'b000, 3'b010, 1'b0};
   localparam out_t O_AIWB = {7'b0000000, 2'b00, 1'b0, 2'b00, 3'b001, 3'b000, 1'b0};
   localparam out_t O_JMP  = {7'b0000101, 2'b10, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0};

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
   localparam logic [5:0] BAD = 6'b111111, F_SUB = 6'b100010;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic [5:0] fn;
      logic       zf;
      logic       rdy;
      logic [3:0] st;
      out_t       o;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic out_t got_out();
      return {mem_req, MemWrite, IorD, IRWrite, PCWrite, Branch, pc_en, PCSrc,
              ALUSrcA, ALUSrcB, RegDst, MemtoReg, RegWrite, alu_control, illegal_op};
   endfunction

   task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic zf, input logic rdy, input logic [3:0] st, input out_t o);
      vec_t v;
      v.rst = r; v.op = op; v.fn = fn; v.zf = zf; v.rdy = rdy; v.st = st; v.o = o;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [3:0] exp_st, input out_t exp_o);
      out_t g;
      g = got_out();
      checks++;
      if (state !== exp_st || g !== exp_o) begin
         errors++;
         $display("FAIL %s: got state=%0d outs=%b, want state=%0d outs=%b",
                  name, state, g, exp_st, exp_o);
      end
   endtask

   // Drive one cycle's inputs at negedge, compare just after, let the posedge advance.
   task automatic apply(input string name, input vec_t v);
      @(negedge clk);
      rst = v.rst; opcode = v.op; funct = v.fn; zero_flag = v.zf; mem_ready = v.rdy;
      #1;
      check(name, v.st, v.o);
   endtask

   initial begin
      rst = 1'b1; opcode = '0; funct = '0; zero_flag = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);

      // lw, mem_ready high throughout
      add(0, LW, 0, 0, 1, 0, O_FRDY);
      add(0, LW, 0, 1, 1, 1, O_DEC);
      add(0, LW, 0, 0, 1, 2, O_MADR);
      add(0, LW, 0, 0, 1, 3, O_MRD);
      add(0, LW, 0, 1, 1, 4, O_MWB);
      // sw with three stall cycles in MEMWR
      add(0, SW, 0, 0, 1, 0, O_FRDY);
      add(0, SW, 0, 0, 1, 1, O_DEC);
      add(0, SW, 0, 0, 1, 2, O_MADR);
      add(0, SW, 0, 0, 0, 5, O_MWR);
      add(0, SW, 0, 0, 0, 5, O_MWR);
      add(0, SW, 0, 0, 0, 5, O_MWR);
      add(0, SW, 0, 0, 1, 5, O_MWR);
      // R-type sub
      add(0, RT, F_SUB, 0, 1, 0, O_FRDY);
      add(0, RT, F_SUB, 0, 1, 1, O_DEC);
      add(0, RT, F_SUB, 0, 1, 6, O_EXSB);
      add(0, RT, F_SUB, 1, 1, 7, O_ALWB);
      // R-type unknown funct
      add(0, RT, BAD, 0, 1, 0, O_FRDY);
      add(0, RT, BAD, 0, 1, 1, O_ILL);
      // beq taken, with one fetch stall
      add(0, BEQ, 0, 1, 0, 0, O_FSTL);
      add(0, BEQ, 0, 1, 1, 0, O_FRDY);
      add(0, BEQ, 0, 1, 1, 1, O_DEC);
      add(0, BEQ, 0, 1, 0, 8, O_BRZ1);
      // beq not taken
      add(0, BEQ, 0, 0, 1, 0, O_FRDY);
      add(0, BEQ, 0, 0, 1, 1, O_DEC);
      add(0, BEQ, 0, 0, 1, 8, O_BRZ0);
      // addi
      add(0, ADDI, 0, 0, 1, 0, O_FRDY);
      add(0, ADDI, 0, 0, 1, 1, O_DEC);
      add(0, ADDI, 0, 1, 0, 9, O_AIEX);
      add(0, ADDI, 0, 1, 0, 10, O_AIWB);
      // j
      add(0, JMP, 0, 0, 1, 0, O_FRDY);
      add(0, JMP, 0, 0, 1, 1, O_DEC);
      add(0, JMP, 0, 0, 0, 11, O_JMP);
      // illegal opcode
      add(0, BAD, 0, 0, 1, 0, O_FRDY);
      add(0, BAD, 0, 0, 1, 1, O_ILL);
      // lw with one MEMRD stall
      add(0, LW, 0, 0, 1, 0, O_FRDY);
      add(0, LW, 0, 0, 1, 1, O_DEC);
      add(0, LW, 0, 0, 1, 2, O_MADR);
      add(0, LW, 0, 0, 0, 3, O_MRD);
      add(0, LW, 0, 0, 1, 3, O_MRD);
      add(0, LW, 0, 0, 1, 4, O_MWB);
      add(0, LW, 0, 0, 0, 0, O_FSTL);

      foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

      // Reset asserted mid-store while the memory is stalling.
      vecs.delete();
      add(0, SW, 0, 0, 1, 0, O_FRDY);
      add(0, SW, 0, 0, 1, 1, O_DEC);
      add(0, SW, 0, 0, 1, 2, O_MADR);
      add(0, SW, 0, 0, 0, 5, O_MWR);
      add(1, SW, 0, 0, 0, 5, O_RST);
      add(1, SW, 0, 0, 0, 0, O_RST);
      add(0, SW, 0, 0, 0, 0, O_FSTL);
      add(0, SW, 0, 0, 0, 0, O_FSTL);
      add(0, SW, 0, 0, 1, 0, O_FRDY);
      add(0, SW, 0, 0, 1, 1, O_DEC);
      foreach (vecs[i]) apply($sformatf("rst%0d", i), vecs[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Finite-state controller that sequences a multi-cycle MIPS datapath through fetch, decode, execute, memory and write-back. It shares a single memory port and the main ALU across instruction phases. Memory access stalls are handled with a `mem_ready` handshake. Every datapath mux select, the ALU operation and all write strobes come from this block.

## Interface
Parameters:
- None. Opcode and funct encodings are fixed MIPS-I values.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: `instruction[31:26]` from the instruction register.
- `funct` in 6: `instruction[5:0]` from the instruction register.
- `zero_flag` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access requested.
- `MemWrite` out 1: write strobe for the requested access.
- `IorD` out 1: address select; 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: load the instruction register.
- `PCWrite` out 1: unconditional PC write.
- `Branch` out 1: conditional branch phase.
- `pc_en` out 1: PC enable, equal to `PCWrite | (Branch & zero_flag)`.
- `PCSrc` out 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUSrcA` out 1: ALU A select; 0 = PC, 1 = register A.
- `ALUSrcB` out 2: ALU B select; 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `RegDst` out 1: destination register; 0 = rt, 1 = rd.
- `MemtoReg` out 1: write-back data; 0 = ALUOut, 1 = memory data register.
- `RegWrite` out 1: register file write strobe.
- `alu_control` out 3: ALU operation; 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal_op` out 1: one-cycle pulse in DECODE for an unsupported opcode or R-type funct.
- `state` out 4: current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- All outputs are decoded from `state`. Signals not listed for a state are 0.
- FETCH:
  - Drives `mem_req`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, add, `PCSrc`=00.
  - `IRWrite` and `PCWrite` equal `mem_ready`.
  - Goes to DECODE when `mem_ready`=1, otherwise stays.
- DECODE:
  - Drives `ALUSrcA`=0, `ALUSrcB`=11, add, which precomputes the branch target.
  - Next state by opcode: 100011 or 101011 → MEMADR; 000000 → EXEC; 000100 → BRANCH; 001000 → ADDIEX; 000010 → JUMP.
  - Any other opcode → FETCH with `illegal_op`=1.
- MEMADR: drives `ALUSrcA`=1, `ALUSrcB`=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: drives `mem_req`=1, `IorD`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: drives `RegDst`=0, `MemtoReg`=1, `RegWrite`=1. Goes to FETCH.
- MEMWR: drives `mem_req`=1, `IorD`=1, `MemWrite`=1. Holds until `mem_ready`, then goes to FETCH.
- EXEC:
  - Drives `ALUSrcA`=1, `ALUSrcB`=00; `alu_control` from `funct`: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Goes to ALUWB.
- ALUWB: drives `RegDst`=1, `MemtoReg`=0, `RegWrite`=1. Goes to FETCH.
- R-type with an unknown funct:
  - In DECODE: `illegal_op`=1 and the next state is FETCH; no register write.
  - EXEC is never entered with an unknown funct; if it were, the default `alu_control` is 010.
- BRANCH: drives `ALUSrcA`=1, `ALUSrcB`=00, sub, `Branch`=1, `PCSrc`=01. Goes to FETCH.
- ADDIEX: drives `ALUSrcA`=1, `ALUSrcB`=10, add. Goes to ADDIWB.
- ADDIWB: drives `RegDst`=0, `MemtoReg`=0, `RegWrite`=1. Goes to FETCH.
- JUMP: drives `PCSrc`=10, `PCWrite`=1. Goes to FETCH.
- Unused encodings 12–15 go to FETCH; all strobes are 0 while in them.

## Timing
- Reset:
  - While `rst`=1, `mem_req`, `MemWrite`, `IRWrite`, `PCWrite`, `Branch`, `pc_en`, `RegWrite` and `illegal_op` are forced to 0.
  - The other outputs take their FETCH values.
  - The first edge with `rst`=1 loads FETCH. Reset mid-instruction aborts the instruction; no write strobe is issued after that edge.
- Latency in cycles with `mem_ready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_req`, `IorD` and `MemWrite` stay stable during a stall.
- `MemWrite` stays high through a stalled write; memory commits only on the `mem_ready`=1 cycle.
- `mem_ready` is ignored in all other states.
- `pc_en` is combinational in `zero_flag` during BRANCH only. `zero_flag` is don't-care in every other state.
- `IRWrite` and `PCWrite` in FETCH are one-cycle pulses coincident with `mem_ready`=1.

## Test plan
- Reset: assert `rst` in MEMWR with `mem_ready`=0, deassert it → `state`=0, `MemWrite` 0 during reset, and no write strobe follows.
- lw, `mem_ready`=1 throughout → states 0,1,2,3,4,0. `RegWrite`=1 only in state 4, with `MemtoReg`=1 and `RegDst`=0.
- sw with `mem_ready` low for 3 cycles in MEMWR → `MemWrite` high for 4 consecutive cycles, then the next state is FETCH.
- R-type sub (funct 100010) → `alu_control`=110 in EXEC; `RegWrite`=1 with `RegDst`=1 in ALUWB. Then funct 111111 → `illegal_op` pulses and the next state is FETCH.
- beq with `zero_flag`=1 → `pc_en`=1 and `PCSrc`=01 in BRANCH. Repeat with `zero_flag`=0 → `pc_en`=0.
- j → `PCWrite`=1 and `PCSrc`=10 in JUMP. Opcode 111111 → `illegal_op`=1 in DECODE and returns to FETCH in 2 cycles.
